// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state type, default widths and select helper for the APB requester
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DERR   = 2'd3
  } apb_state_e;

  localparam int APB_ADDR_WIDTH     = 8;
  localparam int APB_DATA_WIDTH     = 32;
  localparam int APB_NUM_SLAVES     = 4;
  localparam int APB_SEL_BITS       = 2;
  localparam int APB_TIMEOUT_CYCLES = 16;
  localparam int APB_MAX_SLAVES     = 32;

  // Indices past the vector shift out to all-zero, which the decoder relies on.
  function automatic logic [APB_MAX_SLAVES-1:0] onehot_sel(input int unsigned idx);
    logic [APB_MAX_SLAVES-1:0] one;
    one = {{(APB_MAX_SLAVES-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - slave index to one-hot select plus out-of-range flag
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES = APB_NUM_SLAVES,
  parameter int SEL_BITS   = APB_SEL_BITS
)(
  input  logic [SEL_BITS-1:0]   idx_i,
  output logic [NUM_SLAVES-1:0] sel_o,
  output logic                  decode_err_o
);

  logic [APB_MAX_SLAVES-1:0] w_onehot;

  assign w_onehot = onehot_sel(32'(idx_i));
  assign sel_o    = w_onehot[NUM_SLAVES-1:0];

  // Any hot bit above the populated slaves means the index has no target.
  generate
    if (NUM_SLAVES < APB_MAX_SLAVES) begin : g_partial
      assign decode_err_o = |w_onehot[APB_MAX_SLAVES-1:NUM_SLAVES];
    end else begin : g_full
      assign decode_err_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/apb_multi_slave_master.sv
// rtl/apb_multi_slave_master.sv - APB requester decoding upper address bits onto NUM_SLAVES selects
// Optional ACCESS-phase timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_multi_slave_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int NUM_SLAVES     = APB_NUM_SLAVES,
  parameter int SEL_BITS       = APB_SEL_BITS,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
)(
  input  logic                           pclk,
  input  logic                           preset,
  input  logic                           trans_i,
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic                           wr_rd_i,
  output logic                           ready_o,
  output logic [NUM_SLAVES-1:0]          pselx,
  output logic                           penable,
  output logic                           pwrite,
  output logic [ADDR_WIDTH-1:0]          paddr,
  output logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [NUM_SLAVES-1:0]          pready,
  input  logic [NUM_SLAVES-1:0]          pslverr,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic                           trans_err_o,
  output logic                           done_o
);

  generate
    if (((1 << SEL_BITS) < NUM_SLAVES) || (SEL_BITS > 5) || (SEL_BITS > ADDR_WIDTH) ||
        (NUM_SLAVES < 1) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
      $error("apb_multi_slave_master: inconsistent parameters");
    end
  endgenerate

  apb_state_e              r_state, w_state_nxt;
  logic [SEL_BITS-1:0]     r_idx, w_idx_nxt, w_dec_idx;
  logic [NUM_SLAVES-1:0]   r_sel, w_sel_nxt, w_dec_sel;
  logic                    w_dec_err;
  logic                    r_penable, w_penable_nxt;
  logic                    r_write, w_write_nxt;
  logic                    r_err, w_err_nxt;
  logic                    r_done, w_done_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_nxt;
  logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_nxt;
  logic [DATA_WIDTH-1:0]   w_prdata_arr [NUM_SLAVES];
  logic                    w_pready_sel;
  logic                    w_pslverr_sel;
  logic [DATA_WIDTH-1:0]   w_prdata_sel;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
`endif

  assign w_dec_idx = addr_i[ADDR_WIDTH-1 -: SEL_BITS];

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_BITS   (SEL_BITS)
  ) u_decoder (
    .idx_i        (w_dec_idx),
    .sel_o        (w_dec_sel),
    .decode_err_o (w_dec_err)
  );

  generate
    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_unpack
      assign w_prdata_arr[k] = prdata[k*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Only the latched slave's response is ever looked at.
  assign w_pready_sel  = pready[r_idx];
  assign w_pslverr_sel = pslverr[r_idx];
  assign w_prdata_sel  = w_prdata_arr[r_idx];

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_sel_nxt     = r_sel;
    w_penable_nxt = r_penable;
    w_write_nxt   = r_write;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_rdata_nxt   = r_rdata;
    w_err_nxt     = r_err;
    w_done_nxt    = 1'b0;
`ifdef APB_TIMEOUT_EN
    w_cnt_nxt     = r_cnt;
`endif
    unique case (r_state)
      IDLE: begin
        if (trans_i) begin
          if (w_dec_err) begin
            w_state_nxt = DERR;
          end else begin
            w_state_nxt   = SETUP;
            w_idx_nxt     = w_dec_idx;
            w_sel_nxt     = w_dec_sel;
            w_penable_nxt = 1'b0;
            w_write_nxt   = wr_rd_i;
            w_addr_nxt    = addr_i;
            w_wdata_nxt   = wdata_i;
          end
        end
      end
      SETUP: begin
        w_state_nxt   = ACCESS;
        w_penable_nxt = 1'b1;
`ifdef APB_TIMEOUT_EN
        w_cnt_nxt     = '0;
`endif
      end
      ACCESS: begin
        if (w_pready_sel) begin
          w_state_nxt   = IDLE;
          w_sel_nxt     = '0;
          w_penable_nxt = 1'b0;
          w_done_nxt    = 1'b1;
          w_err_nxt     = w_pslverr_sel;
          if (!r_write) begin
            w_rdata_nxt = w_prdata_sel;
          end
        end
`ifdef APB_TIMEOUT_EN
        // The abort edge is the TIMEOUT_CYCLES-th ACCESS cycle without pready.
        else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt   = IDLE;
          w_sel_nxt     = '0;
          w_penable_nxt = 1'b0;
          w_done_nxt    = 1'b1;
          w_err_nxt     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end
      DERR: begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
        w_err_nxt   = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_sel     <= '0;
      r_penable <= 1'b0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_sel     <= w_sel_nxt;
      r_penable <= w_penable_nxt;
      r_write   <= w_write_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_rdata   <= w_rdata_nxt;
      r_err     <= w_err_nxt;
      r_done    <= w_done_nxt;
`ifdef APB_TIMEOUT_EN
      r_cnt     <= w_cnt_nxt;
`endif
    end
  end

  assign ready_o     = (r_state == IDLE);
  assign pselx       = r_sel;
  assign penable     = r_penable;
  assign pwrite      = r_write;
  assign paddr       = r_addr;
  assign pwdata      = r_wdata;
  assign rdata_o     = r_rdata;
  assign trans_err_o = r_err;
  assign done_o      = r_done;

endmodule

// File: doc/apb_multi_slave_master.md
Name: apb_multi_slave_master

Overview:
- Next-generation APB requester: accepts one user transaction at a time (trans_i/addr_i/wdata_i/wr_rd_i) and runs a standard two-phase APB transfer (SETUP, then ACCESS).
- Unlike the single-slave master, it decodes the upper address bits to drive one of NUM_SLAVES select lines and muxes the per-slave pready/prdata/pslverr responses.
- Flags decode errors without issuing a bus transfer and reports completion on a done pulse.
- Sits between the stimulus/driver side and a bank of slave memories.

Parameters:
- ADDR_WIDTH, 8, address width including slave-select bits.
- DATA_WIDTH, 32, data bus width.
- NUM_SLAVES, 4, number of APB slaves (1..2**SEL_BITS).
- SEL_BITS, 2, upper addr_i bits used as slave index (localparam check: 2**SEL_BITS >= NUM_SLAVES).
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit (used only with APB_TIMEOUT_EN).

Ports:
- pclk  in  1  clock.
- preset  in  1  asynchronous reset, active-high.
- trans_i  in  1  transaction request.
- addr_i  in  ADDR_WIDTH  transaction address.
- wdata_i  in  DATA_WIDTH  write data.
- wr_rd_i  in  1  1=write, 0=read.
- ready_o  out  1  master idle; request accepted when trans_i & ready_o.
- pselx  out  NUM_SLAVES  one-hot slave select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address (full addr_i).
- pwdata  out  DATA_WIDTH  APB write data.
- pready  in  NUM_SLAVES  per-slave ready.
- pslverr  in  NUM_SLAVES  per-slave error.
- prdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data; slave k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- rdata_o  out  DATA_WIDTH  read result.
- trans_err_o  out  1  error status of the completing transfer.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, preset=1): state IDLE; pselx=0, penable=0, pwrite=0, paddr=0, pwdata=0, rdata_o=0, trans_err_o=0, done_o=0. ready_o=1 once the state is IDLE.
- ready_o = (state==IDLE), registered-state decode, no combinational path from trans_i.
- IDLE:
  - On an edge with trans_i=1, latch addr, wdata, wr_rd and index idx = addr_i[ADDR_WIDTH-1 -: SEL_BITS].
  - If idx < NUM_SLAVES: go to SETUP; pselx[idx]=1, paddr/pwdata/pwrite driven, penable=0.
  - If idx >= NUM_SLAVES: go to DERR.
- DERR: one cycle, no pselx activity. Next edge: done_o=1, trans_err_o=1, rdata_o unchanged, return to IDLE.
- SETUP: exactly one cycle. Next state is ACCESS with penable=1; pselx/paddr/pwdata/pwrite held stable.
- ACCESS: waits while pready[idx]=0, with all APB outputs held stable. On the edge where pready[idx]=1:
  - pselx=0, penable=0.
  - done_o=1 for one cycle; trans_err_o=pslverr[idx].
  - Read only: rdata_o = prdata slice idx. On a write, rdata_o holds its previous value.
  - Return to IDLE.
- Responses from unselected slaves are ignored entirely.
- trans_err_o holds its value until the next done_o.
- Minimum latency: accept at edge N, SETUP N..N+1, ACCESS N+1..N+2, done_o high after edge N+2 (zero wait states). The next accept is possible at edge N+3.
- trans_i while not ready: ignored. The driver must hold trans_i until accepted.
- Reset mid-transfer: immediate abort to reset values, no done_o.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - An ACCESS-cycle counter (width $clog2(TIMEOUT_CYCLES+1)) clears in SETUP and increments each ACCESS cycle with pready[idx]=0.
  - When it reaches TIMEOUT_CYCLES: abort with pselx=0, penable=0, done_o=1, trans_err_o=1, rdata_o unchanged, then IDLE.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- apb_pkg holds:
  - state enum apb_state_e {IDLE, SETUP, ACCESS, DERR};
  - default width constants;
  - a function for one-hot select from index.
- One sub-module, apb_addr_decoder (combinational): idx -> one-hot pselx value plus decode_err flag.
- FSM, latches and response mux stay in the top.

Test Plan:
- Write 0x0000_00AA to addr 0x45 (slave 1), pready[1] immediately high -> pselx=0010 for 2 cycles, penable in the 2nd cycle only, done_o after 3 edges, trans_err_o=0.
- Read addr 0xC3 (slave 3) with slave 3 returning 0xDEAD_BEEF after 3 wait states -> penable held 4 cycles, rdata_o=0xDEADBEEF, pselx stable throughout.
- NUM_SLAVES=3, read addr 0xC0 -> no pselx asserted, done_o with trans_err_o=1, rdata_o unchanged.
- Write to slave 2 with pslverr[2]=1 while pslverr[0]=1 and pready[0]=1 -> only slave 2's response is used; completes when pready[2]=1; trans_err_o=1.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready held 0 -> abort after 16 ACCESS cycles, done_o=1, trans_err_o=1. Without the macro, still in ACCESS at cycle 100.
- Assert preset during ACCESS -> all outputs 0 asynchronously, ready_o=1; a following transfer completes normally.
